bus_cycle_sequencer: RTL and testbench



---
 rtl/bus_cycle_sequencer.sv | 175 +++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer
//   Runs every 65816 CPU cycle from hsclk and routes it either to local SRAM
//   (or an internal cycle) at a programmable fast rate, or to the BBC bus. A
//   BBC cycle stretches cpu_phi2 so that its high phase lines up edge-for-edge
//   with a regenerated, delayed copy of bbc_phi0.
//
// Ports
//   hsclk                      single clock
//   reset                      synchronous, active high
//   bbc_phi0                   asynchronous BBC clock
//   cpu_adr[3:0]               cpu_adr[15:12]
//   cpu_vda/vpa/vpb/rnw        65816 status signals
//   map_en                     0 sends every cycle to the BBC
//   cpu_phi2                   CPU clock
//   bbc_phi1/bbc_phi2          regenerated BBC clocks
//   bbc_rnw                    BBC read/write (forced high on fast cycles)
//   bbc_cyc                    current cycle is a BBC cycle
//   ram_ceb/ram_oeb/ram_web    SRAM strobes, active low
//   bbc_drv_en/cpu_drv_en      databus drive enables, active high
module bus_cycle_sequencer #(
    parameter int unsigned FAST_LO     = 2,
    parameter int unsigned FAST_HI     = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PHI_DELAY   = 1,
    parameter logic [3:0]  LOCAL_TOP   = 4'h8
) (
    input  logic       hsclk,
    input  logic       reset,
    input  logic       bbc_phi0,
    input  logic [3:0] cpu_adr,
    input  logic       cpu_vda,
    input  logic       cpu_vpa,
    input  logic       cpu_vpb,
    input  logic       cpu_rnw,
    input  logic       map_en,
    output logic       cpu_phi2,
    output logic       bbc_phi1,
    output logic       bbc_phi2,
    output logic       bbc_rnw,
    output logic       bbc_cyc,
    output logic       ram_ceb,
    output logic       ram_oeb,
    output logic       ram_web,
    output logic       bbc_drv_en,
    output logic       cpu_drv_en
);

    // Synchroniser and delay flops form one chain; its last flop is bbc_phi2,
    // so the phi0->phi2 lag is exactly SYNC_STAGES + PHI_DELAY edges.
    localparam int unsigned ChainLen = SYNC_STAGES + PHI_DELAY;
    localparam int unsigned CntMax   = (FAST_LO > FAST_HI) ? FAST_LO : FAST_HI;
    localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] LoLast = CntW'(FAST_LO - 1);
    localparam logic [CntW-1:0] HiLast = CntW'(FAST_HI - 1);

    typedef enum logic [1:0] {
        StPhi1,
        StFphi2,
        StBwait,
        StBphi2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ChainLen-1:0] chain_q;

    logic bbc_phi1_q;
    logic cpu_phi2_q, bbc_cyc_q, bbc_rnw_q;
    logic ram_ceb_q, ram_oeb_q, ram_web_q;
    logic bbc_drv_en_q, cpu_drv_en_q;

    logic phi2_next, phi2_rise, phi2_fall, is_local;
    logic cpu_phi2_d, bbc_cyc_d, fast_hi_d;

    // Value bbc_phi2 takes on the coming edge; lets the FSM switch cpu_phi2
    // on the very same edge as bbc_phi2.
    assign phi2_next = chain_q[ChainLen-2];
    assign phi2_rise = phi2_next & ~chain_q[ChainLen-1];
    assign phi2_fall = ~phi2_next & chain_q[ChainLen-1];

    // Internal cycles (no VDA/VPA) are local even at BBC addresses; vector
    // fetches always go to the BBC.
    assign is_local = map_en & cpu_vpb & (~(cpu_vda | cpu_vpa) | (cpu_adr < LOCAL_TOP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StPhi1: begin
                if (cnt_q == LoLast) begin
                    cnt_d   = '0;
                    state_d = is_local ? StFphi2 : StBwait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFphi2: begin
                if (cnt_q == HiLast) begin
                    cnt_d   = '0;
                    state_d = StPhi1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Only a genuine 0->1 edge starts the phase, so entry during a
            // high bbc_phi2 waits for the next full high phase.
            StBwait: begin
                if (phi2_rise) begin
                    state_d = StBphi2;
                end
            end
            StBphi2: begin
                if (phi2_fall) begin
                    cnt_d   = '0;
                    state_d = StPhi1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StBwait;
            end
        endcase
    end

    always_comb begin
        cpu_phi2_d = (state_d == StFphi2) || (state_d == StBphi2);
        bbc_cyc_d  = (state_d == StBwait) || (state_d == StBphi2);
        fast_hi_d  = (state_d == StFphi2);
    end

    // All outputs are registered from next-state values so they change only
    // on hsclk edges and never glitch.
    always_ff @(posedge hsclk) begin
        if (reset) begin
            chain_q      <= '0;
            bbc_phi1_q   <= 1'b1;
            state_q      <= StBwait;
            cnt_q        <= '0;
            cpu_phi2_q   <= 1'b0;
            bbc_cyc_q    <= 1'b1;
            bbc_rnw_q    <= 1'b1;
            ram_ceb_q    <= 1'b1;
            ram_oeb_q    <= 1'b1;
            ram_web_q    <= 1'b1;
            bbc_drv_en_q <= 1'b0;
            cpu_drv_en_q <= 1'b0;
        end else begin
            chain_q      <= {chain_q[ChainLen-2:0], bbc_phi0};
            bbc_phi1_q   <= ~phi2_next;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cpu_phi2_q   <= cpu_phi2_d;
            bbc_cyc_q    <= bbc_cyc_d;
            bbc_rnw_q    <= bbc_cyc_d ? cpu_rnw : 1'b1;
            ram_ceb_q    <= ~fast_hi_d;
            ram_oeb_q    <= ~(fast_hi_d & cpu_rnw);
            // The last fast high cycle holds write data with WE released.
            ram_web_q    <= ~(fast_hi_d & ~cpu_rnw & (cnt_d < HiLast));
            bbc_drv_en_q <= bbc_cyc_d & ~cpu_rnw & phi2_next;
            cpu_drv_en_q <= bbc_cyc_d & cpu_rnw & cpu_phi2_d;
        end
    end

    assign cpu_phi2   = cpu_phi2_q;
    assign bbc_phi1   = bbc_phi1_q;
    assign bbc_phi2   = chain_q[ChainLen-1];
    assign bbc_rnw    = bbc_rnw_q;
    assign bbc_cyc    = bbc_cyc_q;
    assign ram_ceb    = ram_ceb_q;
    assign ram_oeb    = ram_oeb_q;
    assign ram_web    = ram_web_q;
    assign bbc_drv_en = bbc_drv_en_q;
    assign cpu_drv_en = cpu_drv_en_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Testbench for bus_cycle_sequencer: behavioural cycle model checked every
// cycle, directed scenarios with literal expectations, and a PHI_DELAY sweep.
module tb_bus_cycle_sequencer;

    localparam int FastLo = 2;
    localparam int FastHi = 2;
    localparam int Lag    = 3;     // SYNC_STAGES 2 + PHI_DELAY 1 for the main DUT

    logic       hsclk = 1'b0;
    logic       reset;
    logic       bbc_phi0 = 1'b0;
    logic [3:0] cpu_adr;
    logic       cpu_vda, cpu_vpa, cpu_vpb, cpu_rnw, map_en;
    logic       cpu_phi2, bbc_phi1, bbc_phi2, bbc_rnw, bbc_cyc;
    logic       ram_ceb, ram_oeb, ram_web, bbc_drv_en, cpu_drv_en;

    logic [4:0] sw_cpu_phi2, sw_bbc_phi1, sw_bbc_phi2, sw_bbc_rnw, sw_bbc_cyc;
    logic [4:0] sw_ram_ceb, sw_ram_oeb, sw_ram_web, sw_bbc_drv_en, sw_cpu_drv_en;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 hsclk = ~hsclk;

    bus_cycle_sequencer u_dut (
        .hsclk      (hsclk),
        .reset      (reset),
        .bbc_phi0   (bbc_phi0),
        .cpu_adr    (cpu_adr),
        .cpu_vda    (cpu_vda),
        .cpu_vpa    (cpu_vpa),
        .cpu_vpb    (cpu_vpb),
        .cpu_rnw    (cpu_rnw),
        .map_en     (map_en),
        .cpu_phi2   (cpu_phi2),
        .bbc_phi1   (bbc_phi1),
        .bbc_phi2   (bbc_phi2),
        .bbc_rnw    (bbc_rnw),
        .bbc_cyc    (bbc_cyc),
        .ram_ceb    (ram_ceb),
        .ram_oeb    (ram_oeb),
        .ram_web    (ram_web),
        .bbc_drv_en (bbc_drv_en),
        .cpu_drv_en (cpu_drv_en)
    );

    for (genvar g = 0; g < 5; g++) begin : g_sweep
        bus_cycle_sequencer #(.PHI_DELAY(g)) u_sw (
            .hsclk      (hsclk),
            .reset      (reset),
            .bbc_phi0   (bbc_phi0),
            .cpu_adr    (cpu_adr),
            .cpu_vda    (cpu_vda),
            .cpu_vpa    (cpu_vpa),
            .cpu_vpb    (cpu_vpb),
            .cpu_rnw    (cpu_rnw),
            .map_en     (map_en),
            .cpu_phi2   (sw_cpu_phi2[g]),
            .bbc_phi1   (sw_bbc_phi1[g]),
            .bbc_phi2   (sw_bbc_phi2[g]),
            .bbc_rnw    (sw_bbc_rnw[g]),
            .bbc_cyc    (sw_bbc_cyc[g]),
            .ram_ceb    (sw_ram_ceb[g]),
            .ram_oeb    (sw_ram_oeb[g]),
            .ram_web    (sw_ram_web[g]),
            .bbc_drv_en (sw_bbc_drv_en[g]),
            .cpu_drv_en (sw_cpu_drv_en[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // bbc_phi0 source: free-running 32-hsclk period, or held at phi0_hold.
    // Changes 2 time units after a rising edge, well away from sampling.
    bit phi0_run  = 1'b1;
    bit phi0_hold = 1'b0;
    int phi0_cnt  = 0;
    always @(posedge hsclk) begin
        #2;
        if (phi0_run) begin
            if (phi0_cnt == 15) begin
                phi0_cnt = 0;
                bbc_phi0 = ~bbc_phi0;
            end else begin
                phi0_cnt++;
            end
        end else begin
            bbc_phi0 = phi0_hold;
        end
    end

    // ---------------- behavioural model ----------------
    // bbc_phi2 is phi0 as seen Lag edges ago. A CPU cycle is a low phase of
    // FastLo edges, then either FastHi fast high edges or a BBC high phase
    // that starts at the next bbc_phi2 rise and ends at its fall.
    bit m_valid = 1'b0;
    bit m_samples[$];
    bit m_phi2, m_cpu, m_bbc, m_wait, m_rnw;
    int m_age;

    always @(posedge hsclk) begin
        bit old_phi2;
        old_phi2 = m_phi2;
        if (reset) begin
            m_valid = 1'b1;
            m_samples.delete();
            for (int i = 0; i < Lag; i++) m_samples.push_back(1'b0);
            m_phi2 = 1'b0;
            m_cpu  = 1'b0;
            m_bbc  = 1'b1;
            m_wait = 1'b1;
            m_age  = 0;
            m_rnw  = 1'b1;
        end else begin
            m_samples.push_back(bbc_phi0);
            void'(m_samples.pop_front());
            m_phi2 = m_samples[0];
            m_rnw  = cpu_rnw;
            if (!m_cpu) begin
                if (m_wait) begin
                    if (m_phi2 && !old_phi2) begin
                        m_cpu  = 1'b1;
                        m_wait = 1'b0;
                    end
                end else if (m_age == FastLo - 1) begin
                    m_age = 0;
                    if (map_en && cpu_vpb && (!(cpu_vda || cpu_vpa) || cpu_adr < 4'h8)) begin
                        m_cpu = 1'b1;
                        m_bbc = 1'b0;
                    end else begin
                        m_bbc  = 1'b1;
                        m_wait = 1'b1;
                    end
                end else begin
                    m_age++;
                end
            end else if (m_bbc) begin
                if (!m_phi2 && old_phi2) begin
                    m_cpu = 1'b0;
                    m_bbc = 1'b0;
                    m_age = 0;
                end
            end else if (m_age == FastHi - 1) begin
                m_cpu = 1'b0;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge hsclk) begin
        if (m_valid) begin
            bit fast_hi;
            logic [9:0] act, exp;
            fast_hi = m_cpu && !m_bbc;
            act = {cpu_phi2, bbc_phi1, bbc_phi2, bbc_rnw, bbc_cyc,
                   ram_ceb, ram_oeb, ram_web, bbc_drv_en, cpu_drv_en};
            exp = {m_cpu, !m_phi2, m_phi2, m_bbc ? m_rnw : 1'b1, m_bbc,
                   !fast_hi, !(fast_hi && m_rnw),
                   !(fast_hi && !m_rnw && m_age < FastHi - 1),
                   m_bbc && !m_rnw && m_phi2, m_bbc && m_rnw && m_cpu};
            check("model_outputs", int'(act), int'(exp));
        end
    end

    // ---------------- directed helpers ----------------
    logic prev_cpu, prev_phi2;

    task automatic step();
        prev_cpu  = cpu_phi2;
        prev_phi2 = bbc_phi2;
        @(negedge hsclk);
    endtask

    task automatic wait_cpu_edge(input bit level, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(cpu_phi2 == level && prev_cpu != level) && n < 200);
        check({name, "_edge_seen"}, int'(cpu_phi2 == level && prev_cpu != level), 1);
    endtask

    // Starting on a cpu_phi2 rise, walk one full CPU cycle collecting stats.
    task automatic measure(output int per, output int ceb_lo, output int web_lo,
                           output int rnw_lo, output int cyc_hi);
        per = 0; ceb_lo = 0; web_lo = 0; rnw_lo = 0; cyc_hi = 0;
        do begin
            if (!ram_ceb) ceb_lo++;
            if (!ram_web) web_lo++;
            if (!bbc_rnw) rnw_lo++;
            if (bbc_cyc)  cyc_hi++;
            per++;
            step();
        end while (!(cpu_phi2 && !prev_cpu) && per < 200);
    endtask

    localparam logic [9:0] RstVec = 10'b0_1_0_1_1_1_1_1_0_0;

    initial begin
        int per, ceb_lo, web_lo, rnw_lo, cyc_hi;
        int drv_bad, cdrv_hi, drv_hi;
        reset = 1'b1; map_en = 1'b0; cpu_adr = 4'h0;
        cpu_vda = 1'b1; cpu_vpa = 1'b0; cpu_vpb = 1'b1; cpu_rnw = 1'b1;
        repeat (3) step();

        // Reset values
        check("rst_cpu_phi2", cpu_phi2, 0);
        check("rst_bbc_phi1", bbc_phi1, 1);
        check("rst_bbc_cyc", bbc_cyc, 1);
        check("rst_strobes", {ram_ceb, ram_oeb, ram_web}, 3'b111);
        check("rst_bus", {bbc_rnw, bbc_drv_en, cpu_drv_en}, 3'b100);
        for (int i = 0; i < 5; i++)
            check($sformatf("rst_sweep%0d", i),
                  {sw_cpu_phi2[i], sw_bbc_phi1[i], sw_bbc_phi2[i], sw_bbc_rnw[i], sw_bbc_cyc[i],
                   sw_ram_ceb[i], sw_ram_oeb[i], sw_ram_web[i], sw_bbc_drv_en[i],
                   sw_cpu_drv_en[i]}, RstVec);
        reset = 1'b0;

        // map_en=0: every cpu_phi2 rise is a bbc_phi2 rise
        for (int i = 0; i < 2; i++) begin
            wait_cpu_edge(1'b1, "lock");
            check("lock_rise", {prev_phi2, bbc_phi2, bbc_cyc}, 3'b011);
        end

        // Fast read run
        map_en = 1'b1; cpu_adr = 4'h2;
        wait_cpu_edge(1'b1, "fast_rd");
        wait_cpu_edge(1'b1, "fast_rd2");
        measure(per, ceb_lo, web_lo, rnw_lo, cyc_hi);
        check("fast_rd_period", per, 4);
        check("fast_rd_ceb_lo", ceb_lo, 2);
        check("fast_rd_web_lo", web_lo, 0);
        check("fast_rd_bbc_rnw_lo", rnw_lo, 0);

        // Fast write run
        cpu_rnw = 1'b0;
        wait_cpu_edge(1'b1, "fast_wr");
        measure(per, ceb_lo, web_lo, rnw_lo, cyc_hi);
        check("fast_wr_period", per, 4);
        check("fast_wr_web_lo", web_lo, 1);
        check("fast_wr_bbc_rnw_lo", rnw_lo, 0);

        // Fast -> BBC, address changes while bbc_phi2 is high
        cpu_rnw = 1'b1;
        per = 0;
        while (!bbc_phi2 && per < 100) begin step(); per++; end
        check("f2b_phi2_high", bbc_phi2, 1);
        cpu_adr = 4'hF;
        wait_cpu_edge(1'b1, "f2b_rise");
        check("f2b_rise_lock", {prev_phi2, bbc_phi2, bbc_cyc}, 3'b011);
        wait_cpu_edge(1'b0, "f2b_fall");
        check("f2b_fall_lock", {prev_phi2, bbc_phi2}, 2'b10);

        // Internal cycle at a BBC address runs fast
        cpu_vda = 1'b0; cpu_vpa = 1'b0;
        repeat (80) step();
        wait_cpu_edge(1'b1, "internal");
        measure(per, ceb_lo, web_lo, rnw_lo, cyc_hi);
        check("internal_period", per, 4);
        check("internal_bbc_cyc", cyc_hi, 0);

        // Vector fetch at a local address goes to the BBC
        cpu_vda = 1'b1; cpu_vpb = 1'b0; cpu_adr = 4'h0;
        repeat (80) step();
        wait_cpu_edge(1'b1, "vector");
        check("vector_bbc", {bbc_cyc, ram_ceb, prev_phi2, bbc_phi2}, 4'b1101);

        // BBC write: bbc_drv_en follows bbc_phi2, cpu_drv_en stays low
        cpu_vpb = 1'b1; cpu_adr = 4'hF; cpu_rnw = 1'b0;
        repeat (80) step();
        drv_bad = 0; cdrv_hi = 0; drv_hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (bbc_drv_en != bbc_phi2) drv_bad++;
            if (cpu_drv_en) cdrv_hi++;
            if (bbc_drv_en) drv_hi++;
            step();
        end
        check("bbc_wr_drv_vs_phi2", drv_bad, 0);
        check("bbc_wr_cpu_drv", cdrv_hi, 0);
        check("bbc_wr_drv_hi", drv_hi, 32);

        // Mid-BBC-high reset across PHI_DELAY 0..4
        map_en = 1'b0; cpu_rnw = 1'b1;
        wait_cpu_edge(1'b1, "mid_rst");
        repeat (4) step();
        check("mid_main_hi", {cpu_phi2, bbc_cyc}, 2'b11);
        for (int i = 0; i < 5; i++)
            check($sformatf("mid_sweep%0d_hi", i), {sw_cpu_phi2[i], sw_bbc_cyc[i]}, 2'b11);
        reset = 1'b1;
        phi0_run = 1'b0; phi0_hold = 1'b0;
        step();
        check("mid_main_rst", {cpu_phi2, bbc_cyc}, 2'b01);
        for (int i = 0; i < 5; i++)
            check($sformatf("mid_sweep%0d_rst", i), {sw_cpu_phi2[i], sw_bbc_cyc[i]}, 2'b01);
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();

        // phi0 -> phi2 lag per instance
        begin
            int first [5];
            for (int i = 0; i < 5; i++) first[i] = -1;
            phi0_hold = 1'b1;
            @(posedge hsclk);               // phi0 rises 2 units after this edge
            for (int k = 1; k <= 12; k++) begin
                @(posedge hsclk);
                #1;
                for (int i = 0; i < 5; i++)
                    if (sw_bbc_phi2[i] && first[i] < 0) first[i] = k;
            end
            for (int i = 0; i < 5; i++)
                check($sformatf("lag_sweep%0d", i), first[i], 2 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
